// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART ROM boot loader.
//   - ROM write-port bus widths and write-strobe levels
//   - UART idle line level
//   - receiver FSM state encoding
package uart_rom_loader_pkg;

   localparam int   INST_ADDR_W   = 32;     // ROM byte address bus width
   localparam int   INST_W        = 32;     // ROM instruction word width
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic UART_IDLE     = 1'b1;   // 8N1 line rests high

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx_i          asynchronous serial input (idle high)
//   byte_o        received byte, valid while byte_valid_o is high
//   byte_valid_o  one-cycle pulse: byte received with a good stop bit
//   frame_err_o   one-cycle pulse: byte received with a low stop bit
//   start_o       one-cycle pulse on every start-bit detection
//   idle_o        receiver is waiting for a start bit
module uart_rx_byte
   import uart_rom_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o,
   output logic       start_o,
   output logic       idle_o
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state;
   logic          rx_m;
   logic          rx_s;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m         <= UART_IDLE;
         rx_s         <= UART_IDLE;
         state        <= RX_IDLE;
         bit_timer    <= '0;
         bit_cnt      <= '0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         start_o      <= 1'b0;
         idle_o       <= 1'b1;
      end else begin
         rx_m         <= rx_i;
         rx_s         <= rx_m;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         start_o      <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_s == 1'b0) begin
                  state     <= RX_START;
                  bit_timer <= '0;
                  start_o   <= 1'b1;
                  idle_o    <= 1'b0;
               end
            end
            // Half a bit in: re-check the start bit so short glitches are ignored
            // and every later sample lands near mid-bit.
            RX_START: begin
               if (bit_timer == HALF_LAST) begin
                  bit_timer <= '0;
                  if (rx_s == 1'b0) begin
                     state   <= RX_DATA;
                     bit_cnt <= '0;
                  end else begin
                     state  <= RX_IDLE;
                     idle_o <= 1'b1;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_timer == BIT_LAST) begin
                  bit_timer <= '0;
                  byte_o    <= {rx_s, byte_o[7:1]};   // LSB arrives first
                  if (bit_cnt == 3'd7) state <= RX_STOP;
                  else                 bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            RX_STOP: begin
               if (bit_timer == BIT_LAST) begin
                  bit_timer <= '0;
                  state     <= RX_IDLE;
                  idle_o    <= 1'b1;
                  if (rx_s == UART_IDLE) byte_valid_o <= 1'b1;
                  else                   frame_err_o  <= 1'b1;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            default: begin
               state  <= RX_IDLE;
               idle_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_rom_loader.sv
// UART boot loader driving the instruction ROM write port.
// Bytes arriving on the serial line are packed little-endian into 32-bit
// words and written to consecutive word addresses from BASE_ADDR. A session
// begins at the first start bit and ends after TIMEOUT_BITS idle bit times.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   uart_rx_i     asynchronous serial input (idle high)
//   w_addr_o      ROM write byte address (word aligned)
//   w_data_o      ROM write data
//   w_en_o        one-cycle write strobe per word
//   load_busy_o   download session in progress
//   load_done_o   sticky: last session ended by timeout
//   frame_err_o   sticky: a byte had a low stop bit
//   overflow_o    sticky: a word fell beyond the ROM and was dropped
module uart_rom_loader
   import uart_rom_loader_pkg::*;
#(
   parameter int          CLK_FREQ     = 50_000_000,
   parameter int          BAUD         = 115_200,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int          ADDR_SPAN    = 4096,
   parameter int          TIMEOUT_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx_i,
   output logic [INST_ADDR_W-1:0] w_addr_o,
   output logic [INST_W-1:0]      w_data_o,
   output logic                   w_en_o,
   output logic                   load_busy_o,
   output logic                   load_done_o,
   output logic                   frame_err_o,
   output logic                   overflow_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int TO_CLKS      = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int IW           = $clog2(TO_CLKS);
   localparam logic [IW-1:0]          IDLE_LAST  = IW'(TO_CLKS - 1);
   localparam logic [INST_ADDR_W-1:0] ADDR_LIMIT = BASE_ADDR + 32'(ADDR_SPAN);

   logic [7:0]             rx_byte;
   logic                   byte_valid;
   logic                   ferr_pulse;
   logic                   rx_start;
   logic                   rx_idle;

   logic [INST_ADDR_W-1:0] addr;
   logic [INST_W-1:0]      word;
   logic [1:0]             byte_cnt;
   logic [IW-1:0]          idle_cnt;

   logic                   timeout;
   logic                   do_write;
   logic [INST_W-1:0]      write_word;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (uart_rx_i),
      .byte_o       (rx_byte),
      .byte_valid_o (byte_valid),
      .frame_err_o  (ferr_pulse),
      .start_o      (rx_start),
      .idle_o       (rx_idle)
   );

   // A word is committed either when its fourth byte lands or when the
   // session times out holding a partial word (upper bytes stay zero).
   always_comb begin
      timeout    = load_busy_o && rx_idle && (idle_cnt == IDLE_LAST);
      do_write   = (byte_valid && (byte_cnt == 2'd3)) || (timeout && (byte_cnt != 2'd0));
      write_word = byte_valid ? {rx_byte, word[23:0]} : word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr_o    <= '0;
         w_data_o    <= '0;
         w_en_o      <= WRITE_DISABLE;
         load_busy_o <= 1'b0;
         load_done_o <= 1'b0;
         frame_err_o <= 1'b0;
         overflow_o  <= 1'b0;
         addr        <= BASE_ADDR;
         word        <= '0;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
      end else begin
         w_en_o <= WRITE_DISABLE;

         if (ferr_pulse) frame_err_o <= 1'b1;

         if (rx_start) begin
            idle_cnt <= '0;
         end else if (load_busy_o && rx_idle) begin
            if (timeout) idle_cnt <= '0;
            else         idle_cnt <= idle_cnt + 1'b1;
         end

         if (timeout) begin
            load_busy_o <= 1'b0;
            load_done_o <= 1'b1;
         end

         if (do_write) begin
            if (addr < ADDR_LIMIT) begin
               w_en_o   <= WRITE_ENABLE;
               w_addr_o <= addr;
               w_data_o <= write_word;
               addr     <= addr + 32'd4;
            end else begin
               overflow_o <= 1'b1;
            end
            byte_cnt <= '0;
            word     <= '0;
         end else if (byte_valid) begin
            word[{byte_cnt, 3'b000} +: 8] <= rx_byte;
            byte_cnt                      <= byte_cnt + 1'b1;
         end

         // A start bit outside a session opens a fresh one; it cannot coincide
         // with a byte or a timeout, so it simply takes over the session state.
         if (rx_start && !load_busy_o) begin
            load_busy_o <= 1'b1;
            load_done_o <= 1'b0;
            addr        <= BASE_ADDR;
            byte_cnt    <= '0;
            word        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader (10 clocks per bit, 32-bit timeout,
// 8-byte ROM so the overflow path is reachable). Expected ROM writes go into
// a queue; a monitor pops and compares on every write strobe.
module tb_uart_rom_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [31:0] w_addr_o;
   logic [31:0] w_data_o;
   logic        w_en_o;
   logic        load_busy_o;
   logic        load_done_o;
   logic        frame_err_o;
   logic        overflow_o;

   uart_rom_loader #(
      .CLK_FREQ     (1_000_000),
      .BAUD         (100_000),
      .BASE_ADDR    (32'h0),
      .ADDR_SPAN    (8),
      .TIMEOUT_BITS (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx_i   (rx),
      .w_addr_o    (w_addr_o),
      .w_data_o    (w_data_o),
      .w_en_o      (w_en_o),
      .load_busy_o (load_busy_o),
      .load_done_o (load_done_o),
      .frame_err_o (frame_err_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   time         t_stop = 0;
   time         t_done = 0;
   logic        done_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (w_en_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", w_addr_o, w_data_o);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("wr_addr", w_addr_o, e[63:32]);
            check("wr_data", w_data_o, e[31:0]);
         end
      end
      if (load_done_o === 1'b1 && done_q == 1'b0) t_done = $time;
      done_q <= (load_done_o === 1'b1);
   end

   task automatic bit_period(input logic v);
      rx = v;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      @(posedge clk);
      #1;
      bit_period(1'b0);
      for (int i = 0; i < 8; i++) bit_period(b[i]);
      t_stop = $time;
      bit_period(stop_ok);
      if (!stop_ok) bit_period(1'b1);
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic wait_done(input string name);
      int got;
      got = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (load_done_o === 1'b1) begin
            got = 1;
            break;
         end
      end
      check(name, 32'(got), 32'd1);
      @(negedge clk);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy"}, 32'(load_busy_o), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_addr"},  w_addr_o, 32'h0);
      check({name, "_data"},  w_data_o, 32'h0);
      check({name, "_wen"},   32'(w_en_o), 32'd0);
      check({name, "_busy"},  32'(load_busy_o), 32'd0);
      check({name, "_done"},  32'(load_done_o), 32'd0);
      check({name, "_ferr"},  32'(frame_err_o), 32'd0);
      check({name, "_ovf"},   32'(overflow_o), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint lat;

      // Reset state
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Two full words, then timeout 320 clocks after the last stop-bit sample
      expect_write(32'h0, 32'h0000_0013);
      expect_write(32'h4, 32'h0010_0093);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h93, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_done("t1_done");
      // Stop-bit sample sits 8 clocks into the stop bit (2-flop sync + half bit).
      lat = (t_done - t_stop) / 10;
      n_chk++;
      if (lat < 324 || lat > 332) begin
         n_fail++;
         $display("FAIL t1_done_latency: got %0d clocks expected 328 (+/-4)", lat);
      end

      // Start-bit glitch: session opens but no byte and no error
      @(posedge clk);
      #1;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("t2_busy", 32'(load_busy_o), 32'd1);
      check("t2_done_cleared", 32'(load_done_o), 32'd0);
      wait_done("t2_done");
      check("t2_ferr", 32'(frame_err_o), 32'd0);

      // Bad stop bit, then a clean word
      send_byte(8'h5A, 1'b0);
      check("t3_ferr", 32'(frame_err_o), 32'd1);
      expect_write(32'h0, 32'h4433_2211);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      wait_done("t3_done");

      // Partial word flushed at timeout
      expect_write(32'h0, 32'h0000_55AA);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      wait_done("t4_done");
      check("t4_ferr_sticky", 32'(frame_err_o), 32'd1);

      // Reset mid-word discards the partial data
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("t6_rst");
      rst = 1'b0;
      expect_write(32'h0, 32'h0403_0201);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h04, 1'b1);
      wait_done("t6_done");

      // Three words into an 8-byte ROM: third is dropped
      expect_write(32'h0, 32'h1312_1110);
      expect_write(32'h4, 32'h1716_1514);
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
      @(negedge clk);
      check("t5_ovf_before", 32'(overflow_o), 32'd0);
      for (int i = 8; i < 12; i++) send_byte(8'h10 + 8'(i), 1'b1);
      @(negedge clk);
      check("t5_ovf_after", 32'(overflow_o), 32'd1);
      wait_done("t5_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
